comparator_nway: RTL and testbench

COMPARATOR_NWAY -- requirements
Module: comparator_nway

---
 rtl/comparator_nway.sv | 256 +++++++++++++++++++++++++
 tb/tb_comparator_nway.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_nway.sv
// comparator_nway: redundant-core fingerprint comparator with a round-robin task picker.
// The sequencer locks one task slot and compares the per-core tail fingerprints until
// the FIFOs drain. It then walks the fprint-ready / verified / reset-task / status
// handshakes. With NUM_CORES=3 a single outvoted core is reported and the pass goes on.
// With NUM_CORES=2 any difference is a mismatch.
// Optional build macro: COMP_ACK_TIMEOUT_EN adds a per-state ack-wait timeout.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// IDLE          | no task locked, waiting for any request bit
// SET_TASK      | round-robin winner latched into comp_task
// LOAD          | settle for LOAD_WAIT cycles before the first compare
// CHECK         | decide between fingerprint compare and task completion
// COMPARE       | compare the tail fingerprints of all cores
// INCR_TAIL     | one-cycle pulse to advance the FIFO tail pointers
// CHECK_DONE    | stop comparing once any core's tail reaches its head
// TASK_COMPLETE | check-in seen, confirm all head pointers agree
// RESET_READY   | clear the fprint-ready flag, wait for ack
// MISMATCH      | record the mismatch for this pass
// VERIFIED      | report the verified task, wait for ack
// RESET_TASK    | ask for the task to be reset after a mismatch, wait for ack
// STATUS        | write the status word, wait for ack
module comparator_nway #(
   parameter int NUM_TASKS = 16,
   parameter int CRC_WIDTH = 32,
   parameter int NUM_CORES = 2,
   parameter int LOAD_WAIT = 2,
   parameter int TIMEOUT   = 255,
   localparam int TASK_W   = $clog2(NUM_TASKS)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_TASKS-1:0]           fprints_ready,
   input  logic [NUM_TASKS-1:0]           checkin,
   input  logic [NUM_CORES*CRC_WIDTH-1:0] fprint_flat,
   input  logic [NUM_CORES-1:0]           tail_matches_head,
   input  logic                           heads_match,
   output logic [TASK_W-1:0]              comp_task,
   output logic                           comp_busy,
   output logic                           comp_increment_tail_pointer,
   output logic                           comp_reset_fprint_ready,
   input  logic                           reset_fprint_ack,
   output logic                           comp_task_verified,
   input  logic                           fprint_reg_ack,
   output logic                           comp_reset_task,
   input  logic                           reset_task_ack,
   output logic                           comp_status_write,
   input  logic                           comp_status_ack,
   output logic                           comp_mismatch_detected,
   output logic [NUM_CORES-1:0]           comp_faulty_core,
   output logic                           comp_timeout
);

   typedef enum logic [3:0] {
      IDLE,
      SET_TASK,
      LOAD,
      CHECK,
      COMPARE,
      INCR_TAIL,
      CHECK_DONE,
      TASK_COMPLETE,
      RESET_READY,
      MISMATCH,
      VERIFIED,
      RESET_TASK,
      STATUS
   } state_t;

   localparam logic [TASK_W:0]   NT_W      = (TASK_W+1)'(NUM_TASKS);
   localparam logic [TASK_W-1:0] LAST_TASK = TASK_W'(NUM_TASKS - 1);
   localparam logic [3:0]        LOAD_INIT = 4'(LOAD_WAIT - 1);

   state_t                state;
   state_t                state_nx;
   logic [NUM_TASKS-1:0]  req;
   logic [TASK_W-1:0]     rr_base;
   logic [TASK_W-1:0]     arb_idx;
   logic                  arb_found;
   logic [TASK_W:0]       cand;
   logic [3:0]            load_cnt;
   logic                  cmp_pass;
   logic [NUM_CORES-1:0]  cmp_odd;
   logic                  ack_cur;
   logic                  to_hit;

   assign req = fprints_ready | checkin;

   // Round-robin pick: first requesting slot at or after rr_base, wrapping to 0.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NUM_TASKS; i++) begin
         cand = {1'b0, rr_base} + (TASK_W+1)'(i);
         if (cand >= NT_W) begin
            cand = cand - NT_W;
         end
         if (!arb_found && req[cand[TASK_W-1:0]]) begin
            arb_found = 1'b1;
            arb_idx   = cand[TASK_W-1:0];
         end
      end
   end

   // Fingerprint vote: two cores must agree exactly; three cores tolerate one outlier.
   generate
      if (NUM_CORES == 3) begin : g_tmr
         logic [CRC_WIDTH-1:0] fp0, fp1, fp2;
         logic                 e01, e12, e02;
         assign fp0 = fprint_flat[0*CRC_WIDTH +: CRC_WIDTH];
         assign fp1 = fprint_flat[1*CRC_WIDTH +: CRC_WIDTH];
         assign fp2 = fprint_flat[2*CRC_WIDTH +: CRC_WIDTH];
         assign e01 = (fp0 == fp1);
         assign e12 = (fp1 == fp2);
         assign e02 = (fp0 == fp2);
         assign cmp_pass = e01 | e12 | e02;
         assign cmp_odd  = (e01 & e12) ? 3'b000 :
                           e01         ? 3'b100 :
                           e12         ? 3'b001 :
                           e02         ? 3'b010 : 3'b000;
      end else begin : g_dmr
         assign cmp_pass = (fprint_flat[0 +: CRC_WIDTH] == fprint_flat[CRC_WIDTH +: CRC_WIDTH]);
         assign cmp_odd  = '0;
      end
   endgenerate

   // Ack belonging to the current state; acks for other states are ignored.
   always_comb begin
      ack_cur = 1'b0;
      unique case (state)
         RESET_READY: ack_cur = reset_fprint_ack;
         VERIFIED:    ack_cur = fprint_reg_ack;
         RESET_TASK:  ack_cur = reset_task_ack;
         STATUS:      ack_cur = comp_status_ack;
         default:     ack_cur = 1'b0;
      endcase
   end

`ifdef COMP_ACK_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);

   logic [TO_W-1:0] to_cnt;
   logic            ack_wait;
   logic            timeout_q;

   assign ack_wait = (state == RESET_READY) || (state == VERIFIED) ||
                     (state == RESET_TASK)  || (state == STATUS);
   assign to_hit   = ack_wait && !ack_cur && (to_cnt == TO_W'(TIMEOUT - 1));

   // Cycles spent in the current ack-wait state; restarts on every state change.
   always_ff @(posedge clk) begin
      if (reset) begin
         to_cnt    <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (to_hit) begin
            timeout_q <= 1'b1;
         end
         if (!ack_wait || (state_nx != state)) begin
            to_cnt <= '0;
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end

   assign comp_timeout = timeout_q;
`else
   // TIMEOUT only has meaning when the ack timeout is built in.
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign to_hit         = 1'b0;
   assign comp_timeout   = 1'b0;
`endif

   // Next-state decode.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:          if (arb_found) state_nx = SET_TASK;
         SET_TASK:      state_nx = LOAD;
         LOAD:          if (load_cnt == 4'd0) state_nx = CHECK;
         CHECK: begin
            if (fprints_ready[comp_task]) begin
               state_nx = COMPARE;
            end else if (checkin[comp_task]) begin
               state_nx = TASK_COMPLETE;
            end
         end
         TASK_COMPLETE: state_nx = heads_match ? RESET_READY : MISMATCH;
         COMPARE:       state_nx = cmp_pass ? INCR_TAIL : MISMATCH;
         INCR_TAIL:     state_nx = CHECK_DONE;
         CHECK_DONE:    state_nx = (|tail_matches_head) ? RESET_READY : COMPARE;
         RESET_READY: begin
            if (ack_cur) begin
               state_nx = (checkin[comp_task] || comp_mismatch_detected) ? VERIFIED : IDLE;
            end
         end
         MISMATCH:      state_nx = VERIFIED;
         VERIFIED: begin
            if (ack_cur) begin
               state_nx = comp_mismatch_detected ? RESET_TASK : STATUS;
            end
         end
         RESET_TASK:    if (ack_cur) state_nx = STATUS;
         STATUS:        if (ack_cur) state_nx = IDLE;
         default:       state_nx = IDLE;
      endcase
      if (to_hit) begin
         state_nx = IDLE;
      end
   end

   // State register, task lock, settle counter and per-pass flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state                  <= IDLE;
         comp_task              <= '0;
         rr_base                <= '0;
         load_cnt               <= '0;
         comp_mismatch_detected <= 1'b0;
         comp_faulty_core       <= '0;
      end else begin
         state <= state_nx;
         unique case (state)
            IDLE: begin
               comp_task              <= arb_found ? arb_idx : '0;
               comp_mismatch_detected <= 1'b0;
               comp_faulty_core       <= '0;
            end
            SET_TASK: load_cnt <= LOAD_INIT;
            LOAD:     load_cnt <= load_cnt - 4'd1;
            COMPARE: begin
               if (cmp_pass) begin
                  comp_faulty_core <= comp_faulty_core | cmp_odd;
               end
            end
            MISMATCH: comp_mismatch_detected <= 1'b1;
            default: ;
         endcase
         // The slot just served becomes the lowest priority for the next pick.
         if ((state != IDLE) && (state_nx == IDLE)) begin
            rr_base <= (comp_task == LAST_TASK) ? '0 : comp_task + 1'b1;
         end
      end
   end

   assign comp_busy                   = (state != IDLE);
   assign comp_increment_tail_pointer = (state == INCR_TAIL);
   assign comp_reset_fprint_ready     = (state == RESET_READY);
   assign comp_task_verified          = (state == VERIFIED);
   assign comp_reset_task             = (state == RESET_TASK);
   assign comp_status_write           = (state == STATUS);

endmodule

// File: tb/tb_comparator_nway.sv
// Bench for comparator_nway: a two-core and a three-core instance share the stimulus.
// Only the selected instance sees requests. A per-pass scoreboard holds the expected
// task, flags, pulse counts and pass length, and each record is compared when the
// selected instance returns to idle.
module tb_comparator_nway;
   localparam int NT = 16;
   localparam int CW = 32;
   localparam int LW = 2;
   localparam int TO = 8;

   typedef struct {
      int task_i;
      int mm;
      int faulty;
      int incr;
      int rt;
      int st;
      int rfr;
      int cycles;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [NT-1:0] fprints_ready, checkin;
   logic [2*CW-1:0] fp2;
   logic [3*CW-1:0] fp3;
   logic [1:0]    tail2;
   logic [2:0]    tail3;
   logic          heads_match;
   logic          reset_fprint_ack, fprint_reg_ack, reset_task_ack, comp_status_ack;
   logic          sel3;

   logic [3:0] d2_task, d3_task;
   logic d2_busy, d2_incr, d2_rfr, d2_ver, d2_rt, d2_st, d2_mm, d2_to;
   logic d3_busy, d3_incr, d3_rfr, d3_ver, d3_rt, d3_st, d3_mm, d3_to;
   logic [1:0] d2_faulty;
   logic [2:0] d3_faulty;

   logic [3:0] s_task;
   logic s_busy, s_incr, s_rfr, s_ver, s_rt, s_st, s_mm;
   logic [2:0] s_faulty;

   always #5 clk = ~clk;

   comparator_nway #(.NUM_TASKS(NT), .CRC_WIDTH(CW), .NUM_CORES(2), .LOAD_WAIT(LW), .TIMEOUT(TO)) u_dut2 (
      .clk(clk), .reset(reset),
      .fprints_ready(sel3 ? '0 : fprints_ready), .checkin(sel3 ? '0 : checkin),
      .fprint_flat(fp2), .tail_matches_head(tail2), .heads_match(heads_match),
      .comp_task(d2_task), .comp_busy(d2_busy), .comp_increment_tail_pointer(d2_incr),
      .comp_reset_fprint_ready(d2_rfr), .reset_fprint_ack(reset_fprint_ack),
      .comp_task_verified(d2_ver), .fprint_reg_ack(fprint_reg_ack),
      .comp_reset_task(d2_rt), .reset_task_ack(reset_task_ack),
      .comp_status_write(d2_st), .comp_status_ack(comp_status_ack),
      .comp_mismatch_detected(d2_mm), .comp_faulty_core(d2_faulty), .comp_timeout(d2_to));

   comparator_nway #(.NUM_TASKS(NT), .CRC_WIDTH(CW), .NUM_CORES(3), .LOAD_WAIT(LW), .TIMEOUT(TO)) u_dut3 (
      .clk(clk), .reset(reset),
      .fprints_ready(sel3 ? fprints_ready : '0), .checkin(sel3 ? checkin : '0),
      .fprint_flat(fp3), .tail_matches_head(tail3), .heads_match(heads_match),
      .comp_task(d3_task), .comp_busy(d3_busy), .comp_increment_tail_pointer(d3_incr),
      .comp_reset_fprint_ready(d3_rfr), .reset_fprint_ack(reset_fprint_ack),
      .comp_task_verified(d3_ver), .fprint_reg_ack(fprint_reg_ack),
      .comp_reset_task(d3_rt), .reset_task_ack(reset_task_ack),
      .comp_status_write(d3_st), .comp_status_ack(comp_status_ack),
      .comp_mismatch_detected(d3_mm), .comp_faulty_core(d3_faulty), .comp_timeout(d3_to));

   assign s_task   = sel3 ? d3_task : d2_task;
   assign s_busy   = sel3 ? d3_busy : d2_busy;
   assign s_incr   = sel3 ? d3_incr : d2_incr;
   assign s_rfr    = sel3 ? d3_rfr  : d2_rfr;
   assign s_ver    = sel3 ? d3_ver  : d2_ver;
   assign s_rt     = sel3 ? d3_rt   : d2_rt;
   assign s_st     = sel3 ? d3_st   : d2_st;
   assign s_mm     = sel3 ? d3_mm   : d2_mm;
   assign s_faulty = sel3 ? d3_faulty : {1'b0, d2_faulty};

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb[$];

   bit mon_en = 1'b1;
   bit hold_ack = 1'b0;
   bit hold_status = 1'b0;
   bit prev_busy = 1'b0;
   int passes = 0;
   int stop_after = 1;
   int incr_needed = 1;
   int incr_seen = 0;
   int obs_task, obs_mm, obs_faulty, obs_incr, obs_rt, obs_st, obs_rfr, obs_cycles, obs_chg;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
   endtask

   task automatic clear_obs();
      obs_task = 0; obs_mm = 0; obs_faulty = 0; obs_incr = 0;
      obs_rt = 0; obs_st = 0; obs_rfr = 0; obs_cycles = 0; obs_chg = 0;
   endtask

   task automatic push_exp(input int t, input int mm, input int f, input int inc,
                           input int rt, input int st, input int rfr, input int cyc);
      exp_t e;
      e.task_i = t; e.mm = mm; e.faulty = f; e.incr = inc;
      e.rt = rt; e.st = st; e.rfr = rfr; e.cycles = cyc;
      sb.push_back(e);
   endtask

   // One cycle: responder drives acks / tails / request clears, monitor scores passes.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      reset_fprint_ack = s_rfr && !hold_ack;
      fprint_reg_ack   = s_ver && !hold_ack;
      reset_task_ack   = s_rt  && !hold_ack;
      comp_status_ack  = s_st  && !hold_ack && !hold_status;
      if (s_rfr && passes >= stop_after) fprints_ready = '0;
      if (s_st && passes >= stop_after) begin
         fprints_ready = '0;
         checkin       = '0;
      end
      if (s_incr) incr_seen++;
      if (!s_busy) incr_seen = 0;
      tail2 = (incr_needed != 0 && incr_seen >= incr_needed) ? 2'b11  : 2'b00;
      tail3 = (incr_needed != 0 && incr_seen >= incr_needed) ? 3'b111 : 3'b000;
      if (mon_en) begin
         if (s_busy) begin
            if (!prev_busy) passes++;
            else if (int'(s_task) != obs_task) obs_chg = 1;
            obs_cycles++;
            obs_task   = int'(s_task);
            obs_mm     = int'(s_mm);
            obs_faulty = int'(s_faulty);
            if (s_incr) obs_incr++;
            if (s_rt)   obs_rt  = 1;
            if (s_st)   obs_st  = 1;
            if (s_rfr)  obs_rfr = 1;
         end else if (prev_busy) begin
            check_eq("sb_avail", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check_eq("task",       32'(obs_task),   32'(e.task_i));
               check_eq("task_hold",  32'(obs_chg),    32'd0);
               check_eq("mismatch",   32'(obs_mm),     32'(e.mm));
               check_eq("faulty",     32'(obs_faulty), 32'(e.faulty));
               check_eq("incr_count", 32'(obs_incr),   32'(e.incr));
               check_eq("reset_task", 32'(obs_rt),     32'(e.rt));
               check_eq("status",     32'(obs_st),     32'(e.st));
               check_eq("reset_rdy",  32'(obs_rfr),    32'(e.rfr));
               check_eq("pass_len",   32'(obs_cycles), 32'(e.cycles));
            end
            clear_obs();
         end
         prev_busy = s_busy;
      end
   endtask

   task automatic run_drain(input int budget);
      int n = 0;
      while ((sb.size() != 0 || s_busy) && n < budget) begin
         tick();
         n++;
      end
      check_eq("sb_drained", 32'(sb.size()), 32'd0);
      check_eq("idle_after", 32'(s_busy), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      reset = 1'b1;
      fprints_ready = '0; checkin = '0; fp2 = '0; fp3 = '0;
      tail2 = '0; tail3 = '0; heads_match = 1'b1; sel3 = 1'b0;
      reset_fprint_ack = 1'b0; fprint_reg_ack = 1'b0;
      reset_task_ack = 1'b0; comp_status_ack = 1'b0;
      clear_obs();
      repeat (3) tick();
      check_eq("rst_busy",   32'(d2_busy | d3_busy), 32'd0);
      check_eq("rst_task",   32'({d2_task, d3_task}), 32'd0);
      check_eq("rst_hs",     32'({d2_incr, d2_rfr, d2_ver, d2_rt, d2_st, d3_incr, d3_rfr, d3_ver, d3_rt, d3_st}), 32'd0);
      check_eq("rst_flags",  32'({d2_mm, d2_faulty, d2_to, d3_mm, d3_faulty, d3_to}), 32'd0);
      reset = 1'b0;
      tick();
      check_eq("post_rst_busy", 32'(d2_busy), 32'd0);

      // Two cores, equal fingerprints, tails drained after one increment.
      stop_after = passes + 1; incr_needed = 1;
      fp2 = {32'hA5A5A5A5, 32'hA5A5A5A5};
      fprints_ready = 16'h0001;
      push_exp(0, 0, 0, 1, 0, 0, 1, 1 + LW + 5);
      run_drain(200);

      // Two cores, two compare rounds before the tails catch up.
      stop_after = passes + 1; incr_needed = 2;
      fp2 = {32'h0000_1234, 32'h0000_1234};
      fprints_ready = 16'h0008;
      push_exp(3, 0, 0, 2, 0, 0, 1, 1 + LW + 8);
      run_drain(200);

      // Two cores disagree: mismatch, verified, reset-task, status.
      stop_after = passes + 1; incr_needed = 1;
      fp2 = {32'hDEAD_BEEF, 32'hDEAD_BEEE};
      fprints_ready = 16'h0080;
      push_exp(7, 1, 0, 0, 1, 1, 0, 1 + LW + 6);
      run_drain(200);

      // Continuous check-ins on slots 0 and 2 alternate round-robin.
      stop_after = passes + 4;
      heads_match = 1'b1;
      checkin = 16'h0005;
      push_exp(0, 0, 0, 0, 0, 1, 1, 1 + LW + 5);
      push_exp(2, 0, 0, 0, 0, 1, 1, 1 + LW + 5);
      push_exp(0, 0, 0, 0, 0, 1, 1, 1 + LW + 5);
      push_exp(2, 0, 0, 0, 0, 1, 1, 1 + LW + 5);
      run_drain(400);

      // Check-in with diverged head pointers.
      stop_after = passes + 1;
      heads_match = 1'b0;
      checkin = 16'h0020;
      push_exp(5, 1, 0, 0, 1, 1, 0, 1 + LW + 6);
      run_drain(200);
      heads_match = 1'b1;

      // Three cores: core 2 outvoted.
      sel3 = 1'b1; prev_busy = 1'b0;
      stop_after = passes + 1; incr_needed = 1;
      fp3 = {32'h22, 32'h11, 32'h11};
      fprints_ready = 16'h0002;
      push_exp(1, 0, 3'b100, 1, 0, 0, 1, 1 + LW + 5);
      run_drain(200);

      // Three cores all differ.
      stop_after = passes + 1;
      fp3 = {32'h3, 32'h2, 32'h1};
      fprints_ready = 16'h0200;
      push_exp(9, 1, 0, 0, 1, 1, 0, 1 + LW + 6);
      run_drain(200);

      // Three cores: core 0 outvoted, pick wraps past the top slot.
      stop_after = passes + 1;
      fp3 = {32'h5, 32'h5, 32'h6};
      fprints_ready = 16'h0010;
      push_exp(4, 0, 3'b001, 1, 0, 0, 1, 1 + LW + 5);
      run_drain(200);

      // Reset while waiting in VERIFIED aborts the pass.
      sel3 = 1'b0; mon_en = 1'b0; hold_ack = 1'b1;
      heads_match = 1'b0;
      checkin = 16'h0020;
      n = 0;
      while (!s_ver && n < 60) begin tick(); n++; end
      check_eq("ver_reached", 32'(s_ver), 32'd1);
      check_eq("ver_task", 32'(s_task), 32'd5);
      repeat (2) tick();
      check_eq("ver_held", 32'(s_ver), 32'd1);
      reset = 1'b1;
      tick();
      check_eq("abort_busy", 32'(d2_busy), 32'd0);
      check_eq("abort_task", 32'(d2_task), 32'd0);
      check_eq("abort_hs",   32'({d2_incr, d2_rfr, d2_ver, d2_rt, d2_st}), 32'd0);
      check_eq("abort_flag", 32'({d2_mm, d2_faulty, d2_to}), 32'd0);
      checkin = '0; heads_match = 1'b1;
      reset = 1'b0; hold_ack = 1'b0;
      repeat (3) tick();
      check_eq("abort_stays_idle", 32'(d2_busy), 32'd0);

`ifdef COMP_ACK_TIMEOUT_EN
      // Status ack withheld: the pass is abandoned after TO cycles in STATUS.
      hold_status = 1'b1;
      checkin = 16'h0040;
      n = 0;
      while (!s_st && n < 60) begin tick(); n++; end
      check_eq("to_status_reached", 32'(s_st), 32'd1);
      checkin = '0;
      n = 0;
      while (s_st && n < 100) begin tick(); n++; end
      check_eq("to_cycles", 32'(n + 1), 32'(TO));
      check_eq("to_flag", 32'(d2_to), 32'd1);
      check_eq("to_idle", 32'(d2_busy), 32'd0);
      hold_status = 1'b0;
`else
      check_eq("no_timeout", 32'({d2_to, d3_to}), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
